array_drain: RTL
================

// Module: array_drain
// PURPOSE
//  Read-side sequencer for the systolic MAC array's accumulator readout.
//  - Sweeps the array's element-select index across all SIZE*SIZE accumulators after a compute pass.
//  - Captures each 32-bit result from the array's d_out.
//  - Streams results downstream on a valid/ready interface with index and last tag.
//  - Asserts busy for the whole drain so the controller holds mult_en/acc_en/load_en low.
// PARAMETERS
//  SIZE   4                    array dimension; N = SIZE*SIZE elements drained per pass
//  IDX_W  $clog2(SIZE*SIZE)    width of element index carried on m_idx
// PORTS
//  clk      in   1            single clock, rising edge
//  reset    in   1            asynchronous, active-low (asserted at 0)
//  start    in   1            1-cycle request to begin a drain; ignored unless IDLE
//  d_in     in   32           array result for the current select (combinational from array)
//  select   out  SIZE*SIZE    element index driven to the array's select input
//  busy     out  1            high from accepted start until done
//  done     out  1            1-cycle pulse when the last element has left the output
//  m_data   out  32           result word
//  m_idx    out  IDX_W        row-major element index (i*SIZE+j) of m_data
//  m_last   out  1            high on element N-1 of the drain order
//  m_valid  out  1            output word valid
//  m_ready  in   1            downstream accepts when m_valid&&m_ready
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE.
//    - select, m_data, m_idx all 0; busy, done, m_valid, m_last 0; FIFO emptied.
//    - Reset mid-drain aborts the drain; no done pulse.
//  - FSM states:
//    - IDLE -> DRAIN on start (busy goes high the next cycle).
//    - DRAIN -> FLUSH on the cycle element N-1 is pushed.
//    - FLUSH -> DONE when the FIFO is empty.
//    - DONE -> IDLE unconditionally; done=1 only while in DONE.
//  - Counter cnt, 0..N-1:
//    - select = order(cnt), registered; stable for the whole cycle.
//    - d_in is sampled in the same cycle (the array mux is combinational).
//  - Push in DRAIN when the FIFO is not full, or when it is full and popping the same cycle.
//    - Pushed entry = {d_in, order(cnt), cnt==N-1}; then cnt++.
//    - No push means select and cnt hold.
//  - order(cnt) = cnt (row-major) by default.
//  - Output FIFO: 2 entries; m_* driven from the head.
//    - Pop on m_valid&&m_ready.
//    - m_valid must not drop, and m_data/m_idx/m_last must not change, while m_valid&&!m_ready.
//  - Throughput: 1 element/cycle with m_ready tied high.
//  - Latency: start -> first m_valid = 2 cycles; last push -> done = 1 cycle after the final pop.
//  - start while busy: ignored, with no effect on cnt or the FIFO.
//  - start in the same cycle as DONE: ignored.
//  - cnt reaches N-1 and stops; there is no wrap within a drain; it clears to 0 on entering DRAIN.
//  - select is zero-extended from IDX_W to SIZE*SIZE bits.
// CONFIGURATION
//  - ARRAY_DRAIN_TRANSPOSE_EN defined: drain order is column-major.
//    - order(cnt) = (cnt%SIZE)*SIZE + cnt/SIZE.
//    - m_idx still carries the true row-major index of each word.
//    - m_last is on the element with cnt==N-1.
//  - ARRAY_DRAIN_TRANSPOSE_EN undefined: row-major order only; no transpose logic is synthesised.
// STRUCTURE
//  - Package array_pkg:
//    - SIZE default and N_ELEM localparam.
//    - drain_state_t enum {IDLE, DRAIN, FLUSH, DONE}.
//    - drain_elem_t packed struct {data[31:0], idx, last}.
//  - Sub-module drain_fifo: 2-entry elem FIFO with full/empty, push/pop, async active-low reset.
// TESTING
//  1. SIZE=4, acc[k]=0x100+k, m_ready=1, pulse start.
//     -> 16 words 0x100..0x10F, m_idx 0..15.
//     -> m_last only on idx 15; done 1 cycle after the last pop; busy 18 cycles.
//  2. Same data, m_ready toggles 1,0,1,0.
//     -> m_data stable while stalled; no loss or duplication; select holds when the FIFO is full.
//  3. start pulsed again at cycle 5 of a drain.
//     -> ignored; exactly 16 words; one done pulse.
//  4. reset driven to 0 after word 7.
//     -> all outputs 0 immediately; no done.
//     -> a fresh start afterwards emits idx 0..15 from the beginning.
//  5. m_ready=0 for 10 cycles after start.
//     -> only 2 words buffered; select stalls at 2.
//     -> releasing m_ready delivers 0x100,0x101,0x102... in order.
//  6. ARRAY_DRAIN_TRANSPOSE_EN defined, acc[k]=k.
//     -> select sequence 0,4,8,12,1,5,...,15; m_idx equals select.
//     -> m_last on idx 15; done as in test 1.

Source files
------------

// File: rtl/array_pkg.sv
// Shared types and constants for the accumulator drain sequencer.
// ARRAY_DRAIN_TRANSPOSE_EN selects column-major drain order in order_idx().
package array_pkg;

  localparam int unsigned SIZE   = 4;
  localparam int unsigned N_ELEM = SIZE * SIZE;
  localparam int unsigned IDX_W  = $clog2(N_ELEM);
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } drain_elem_t;

  // Row-major element index visited at drain step cnt.
  function automatic logic [IDX_W-1:0] order_idx(input logic [IDX_W-1:0] cnt);
`ifdef ARRAY_DRAIN_TRANSPOSE_EN
    return IDX_W'((32'(cnt) % SIZE) * SIZE + 32'(cnt) / SIZE);
`else
    return cnt;
`endif
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Two-entry elem FIFO; the head always lives in slot0 so the outputs come
// straight from flops. Occupancy is encoded as {full, valid}.
module drain_fifo
  import array_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  drain_elem_t din,
  output drain_elem_t head,
  output logic        valid,
  output logic        full
);

  drain_elem_t slot1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      slot1 <= '0;
      valid <= 1'b0;
      full  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!valid) begin
            head  <= din;
            valid <= 1'b1;
          end else begin
            slot1 <= din;
            full  <= 1'b1;
          end
        end
        2'b01: begin
          head <= slot1;
          if (full) full <= 1'b0;
          else      valid <= 1'b0;
        end
        2'b11: begin
          // Occupancy unchanged; shift if two deep, else replace the head.
          if (full) begin
            head  <= slot1;
            slot1 <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/array_drain.sv
// Read-side sequencer that sweeps the MAC array's select index and streams
// each accumulator out on valid/ready. ARRAY_DRAIN_TRANSPOSE_EN: column-major.
module array_drain
  import array_pkg::*;
#(
  parameter int unsigned SIZE  = array_pkg::SIZE,
  parameter int unsigned IDX_W = $clog2(SIZE * SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          d_in,
  output logic [SIZE*SIZE-1:0] select,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          m_data,
  output logic [IDX_W-1:0]     m_idx,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam int unsigned SEL_W = SIZE * SIZE;
  localparam int unsigned CNT_W = array_pkg::IDX_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ELEM - 1);

  drain_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  sel_q, sel_d;
  logic              push, pop;
  logic              fifo_valid, fifo_full;
  drain_elem_t       push_elem, head;

  assign pop = fifo_valid && m_ready;

  // Next-state, counter/select advance and FIFO push decision.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    push           = 1'b0;
    push_elem.data = d_in;
    push_elem.idx  = sel_q;
    push_elem.last = (cnt_q == LAST_CNT);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          cnt_d   = '0;
          sel_d   = order_idx('0);
        end
      end
      DRAIN: begin
        push = !fifo_full || pop;
        if (push) begin
          if (cnt_q == LAST_CNT) begin
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            sel_d = order_idx(cnt_q + CNT_W'(1));
          end
        end
      end
      FLUSH: begin
        // Leave as the FIFO goes empty so done lands one cycle after the final pop.
        if (!fifo_valid || (!fifo_full && pop)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

  drain_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_elem),
    .head  (head),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign select  = SEL_W'(sel_q);
  assign m_valid = fifo_valid;
  assign m_data  = head.data;
  assign m_idx   = IDX_W'(head.idx);
  assign m_last  = head.last;

endmodule
